// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with per-operation signed/unsigned mode.
// One multiplier bit is consumed per RUN cycle (LSB first); the product is
// sign-corrected once on the DONE->IDLE edge and held until the next completion.
//
// Optional build macro: SEQ_MULT_EARLY_TERM_EN
//   defined   -> RUN ends as soon as the remaining multiplier magnitude is zero
//   undefined -> RUN always lasts WIDTH cycles
//
// Parameters:
//   WIDTH        operand width (2..32); result is 2*WIDTH bits
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   is_signed    1 = two's-complement operands/result, sampled with start
//   multiplicand operand A, sampled with start
//   multiplier   operand B, sampled with start
//   in_process   high while an operation is in RUN or DONE
//   finish       one-cycle completion pulse
//   result       product, valid from finish onward
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 in_process,
  output logic                 finish,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    acc;
  logic             neg;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic             run_last_c;
  logic             load_c;
  logic             step_c;
  logic             finish_nxt_c;
  logic             in_process_nxt_c;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  always_comb begin
    mag_a_c = multiplicand;
    mag_b_c = multiplier;
    if (is_signed && multiplicand[WIDTH-1]) mag_a_c = WIDTH'(~multiplicand + WIDTH'(1));
    if (is_signed && multiplier[WIDTH-1])   mag_b_c = WIDTH'(~multiplier + WIDTH'(1));
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Last RUN cycle once nothing above the current bit remains to be added.
  always_comb begin
    run_last_c = (mplier[WIDTH-1:1] == '0);
  end
`else
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt;

  // Last RUN cycle is the one processing bit WIDTH-1.
  always_comb begin
    run_last_c = (bit_cnt == LAST_BIT);
  end

  // Bit counter: cleared on acceptance, advanced each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (load_c) begin
      bit_cnt <= '0;
    end else if (step_c) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (run_last_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode; finish/in_process are computed one cycle ahead and registered.
  always_comb begin
    load_c       = 1'b0;
    step_c       = 1'b0;
    finish_nxt_c = 1'b0;
    case (state)
      IDLE:    load_c       = start;
      RUN:     step_c       = 1'b1;
      DONE:    finish_nxt_c = 1'b1;
      default: ;
    endcase
    in_process_nxt_c = (next_state != IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      result     <= '0;
      finish     <= 1'b0;
      in_process <= 1'b0;
    end else begin
      finish     <= finish_nxt_c;
      in_process <= in_process_nxt_c;
      if (load_c) begin
        mcand  <= RW'(mag_a_c);
        mplier <= mag_b_c;
        acc    <= '0;
        neg    <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      end else if (step_c) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // Sign correction applied once, on the DONE->IDLE edge.
      if (finish_nxt_c) begin
        result <= neg ? RW'(~acc + RW'(1)) : acc;
      end
    end
  end

endmodule
